// File: rtl/spec_scoreboard.sv
// spec_scoreboard: issue scoreboard between decode and the functional units.
// Tracks pending register writes, FU occupancy and one speculative branch
// window; grants issue when RAW/WAW/structural/branch hazards are clear and
// squashes speculative work on a branch miss.
// Ports:
//   CLK, nRST                         clock, async active-low reset
//   issue_*                           decoded instruction, issue_ready grant (comb)
//   wb_valid, wb_fu                   writeback ports (FU tag per port)
//   branch_resolved, branch_miss      outstanding branch outcome
//   fu_busy, reg_pending, spec_active registered tracking state
module spec_scoreboard #(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned NUM_FU   = 4,
    parameter int unsigned NUM_WB   = 2,
    parameter int unsigned RW       = $clog2(NUM_REGS),
    parameter int unsigned FW       = $clog2(NUM_FU)
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 issue_valid,
    input  logic [FW-1:0]        issue_fu,
    input  logic [RW-1:0]        issue_rd,
    input  logic                 issue_rd_en,
    input  logic [RW-1:0]        issue_rs1,
    input  logic [RW-1:0]        issue_rs2,
    input  logic [1:0]           issue_rs_en,
    input  logic                 issue_branch,
    output logic                 issue_ready,
    input  logic [NUM_WB-1:0]    wb_valid,
    input  logic [NUM_WB*FW-1:0] wb_fu,
    input  logic                 branch_resolved,
    input  logic                 branch_miss,
    output logic [NUM_FU-1:0]    fu_busy,
    output logic [NUM_REGS-1:0]  reg_pending,
    output logic                 spec_active
);

    logic [NUM_REGS-1:0] r_pending;
    logic [NUM_FU-1:0]   r_busy;
    logic [RW-1:0]       r_fu_rd [NUM_FU];
    logic [NUM_FU-1:0]   r_fu_wr;
    logic [NUM_FU-1:0]   r_fu_spec;
    logic                r_spec_active;

    logic [NUM_FU-1:0]   w_rel_fu;
    logic [NUM_REGS-1:0] w_rel_reg;
    logic [NUM_FU-1:0]   w_sq_fu;
    logic [NUM_REGS-1:0] w_sq_reg;
    logic [NUM_REGS-1:0] w_reg_blk;
    logic                w_squash;
    logic                w_hit;
    logic                w_rs1_ok;
    logic                w_rs2_ok;
    logic                w_rd_ok;
    logic                w_fu_ok;
    logic                w_win_ok;
    logic                w_accept;
    logic                w_issue_spec;
    logic [NUM_REGS-1:0] w_pending_nxt;
    logic [NUM_FU-1:0]   w_busy_nxt;
    logic [NUM_FU-1:0]   w_fu_spec_nxt;
    logic                w_spec_active_nxt;

    assign w_squash = branch_resolved & branch_miss & r_spec_active;
    assign w_hit    = branch_resolved & ~branch_miss & r_spec_active;

    // FU release: a valid wb tag hitting a busy FU; duplicate tags simply OR together
    always_comb begin
        w_rel_fu = '0;
        for (int f = 0; f < int'(NUM_FU); f++) begin
            for (int i = 0; i < int'(NUM_WB); i++) begin
                if (wb_valid[i] && (wb_fu[i*int'(FW) +: FW] == FW'(f)) && r_busy[f]) begin
                    w_rel_fu[f] = 1'b1;
                end
            end
        end
    end

    // Registers freed by release and by squash of speculative writers
    always_comb begin
        w_rel_reg = '0;
        w_sq_reg  = '0;
        for (int r = 0; r < int'(NUM_REGS); r++) begin
            for (int f = 0; f < int'(NUM_FU); f++) begin
                if (r_fu_wr[f] && (r_fu_rd[f] == RW'(r))) begin
                    if (w_rel_fu[f])                 w_rel_reg[r] = 1'b1;
                    if (w_squash && r_fu_spec[f])    w_sq_reg[r]  = 1'b1;
                end
            end
        end
    end

    assign w_sq_fu   = w_squash ? r_fu_spec : '0;
    // Still blocked after the same-cycle writeback bypass
    assign w_reg_blk = r_pending & ~w_rel_reg;

    assign w_rs1_ok = ~issue_rs_en[0] | (issue_rs1 == '0) | ~w_reg_blk[issue_rs1];
    assign w_rs2_ok = ~issue_rs_en[1] | (issue_rs2 == '0) | ~w_reg_blk[issue_rs2];
    assign w_rd_ok  = ~issue_rd_en    | (issue_rd  == '0) | ~w_reg_blk[issue_rd];
    assign w_fu_ok  = ~r_busy[issue_fu] | w_rel_fu[issue_fu];
    assign w_win_ok = ~(issue_branch & r_spec_active & ~branch_resolved);

    // Any miss pulse blocks issue, even when no branch is outstanding
    assign issue_ready = issue_valid & w_rs1_ok & w_rs2_ok & w_rd_ok & w_fu_ok & w_win_ok
                       & ~(branch_resolved & branch_miss);
    assign w_accept     = issue_ready;
    assign w_issue_spec = r_spec_active & ~branch_resolved;

    // Next state: squash and release clear first, then the issue sets win
    always_comb begin
        w_busy_nxt        = r_busy & ~w_rel_fu & ~w_sq_fu;
        w_pending_nxt     = r_pending & ~w_rel_reg & ~w_sq_reg;
        w_fu_spec_nxt     = (w_hit | w_squash) ? '0 : (r_fu_spec & ~w_rel_fu);
        w_spec_active_nxt = (r_spec_active & ~branch_resolved) | (w_accept & issue_branch);
        if (w_accept) begin
            w_busy_nxt[issue_fu]    = 1'b1;
            w_fu_spec_nxt[issue_fu] = w_issue_spec;
            if (issue_rd_en && (issue_rd != '0)) begin
                w_pending_nxt[issue_rd] = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pending     <= '0;
            r_busy        <= '0;
            r_fu_wr       <= '0;
            r_fu_spec     <= '0;
            r_spec_active <= 1'b0;
            for (int f = 0; f < int'(NUM_FU); f++) begin
                r_fu_rd[f] <= '0;
            end
        end else begin
            r_pending     <= w_pending_nxt;
            r_busy        <= w_busy_nxt;
            r_fu_spec     <= w_fu_spec_nxt;
            r_spec_active <= w_spec_active_nxt;
            if (w_accept) begin
                r_fu_rd[issue_fu] <= issue_rd;
                r_fu_wr[issue_fu] <= issue_rd_en;
            end
        end
    end

    assign fu_busy     = r_busy;
    assign reg_pending = r_pending;
    assign spec_active = r_spec_active;

endmodule

// File: tb/tb_spec_scoreboard.sv
// Scoreboard bench for spec_scoreboard: the driver pushes expected responses
// from an instruction-record reference model; a negedge monitor pops and checks.
module tb_spec_scoreboard;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        issue_valid, issue_rd_en, issue_branch, issue_ready;
    logic [1:0]  issue_fu;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic [1:0]  issue_rs_en;
    logic [1:0]  wb_valid;
    logic [3:0]  wb_fu;
    logic        branch_resolved, branch_miss;
    logic [3:0]  fu_busy;
    logic [31:0] reg_pending;
    logic        spec_active;

    spec_scoreboard dut (
        .CLK(CLK), .nRST(nRST),
        .issue_valid(issue_valid), .issue_fu(issue_fu), .issue_rd(issue_rd),
        .issue_rd_en(issue_rd_en), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rs_en(issue_rs_en), .issue_branch(issue_branch), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_fu(wb_fu),
        .branch_resolved(branch_resolved), .branch_miss(branch_miss),
        .fu_busy(fu_busy), .reg_pending(reg_pending), .spec_active(spec_active)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        rdy;
        logic [3:0]  busy;
        logic [31:0] pend;
        logic        sa;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model: one in-flight instruction record per FU
    bit m_busy [4];
    bit m_wr   [4];
    bit m_spec [4];
    int m_rd   [4];
    bit m_sa;
    bit m_rel  [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pend();
        logic [31:0] p = '0;
        for (int f = 0; f < 4; f++)
            if (m_busy[f] && m_wr[f] && m_rd[f] != 0) p[m_rd[f]] = 1'b1;
        return p;
    endfunction

    function automatic logic [3:0] m_busy_vec();
        logic [3:0] b;
        for (int f = 0; f < 4; f++) b[f] = m_busy[f];
        return b;
    endfunction

    // A register is held if an unreleased in-flight writer targets it
    function automatic bit held(input int r);
        if (r == 0) return 0;
        for (int f = 0; f < 4; f++)
            if (m_busy[f] && !m_rel[f] && m_wr[f] && m_rd[f] == r) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        for (int f = 0; f < 4; f++) begin
            m_busy[f] = 0; m_wr[f] = 0; m_spec[f] = 0; m_rd[f] = 0;
        end
        m_sa = 0;
    endtask

    task automatic idle();
        issue_valid = 0; issue_fu = 0; issue_rd = 0; issue_rd_en = 0;
        issue_rs1 = 0; issue_rs2 = 0; issue_rs_en = 0; issue_branch = 0;
        wb_valid = 0; wb_fu = 0; branch_resolved = 0; branch_miss = 0;
    endtask

    task automatic set_issue(input int fu, input int rd, input bit rd_en, input int rs1,
                             input int rs2, input logic [1:0] rs_en, input bit br);
        issue_valid = 1; issue_fu = 2'(fu); issue_rd = 5'(rd); issue_rd_en = rd_en;
        issue_rs1 = 5'(rs1); issue_rs2 = 5'(rs2); issue_rs_en = rs_en; issue_branch = br;
    endtask

    // One cycle: predict, push the expectation, advance the model, clock
    task automatic go(input int exp_rdy);
        exp_t e;
        bit rdy, sq, hit, snow;
        int fu;
        #1;
        for (int f = 0; f < 4; f++) m_rel[f] = 0;
        for (int i = 0; i < 2; i++)
            if (wb_valid[i] && m_busy[wb_fu[i*2 +: 2]]) m_rel[wb_fu[i*2 +: 2]] = 1;
        fu  = int'(issue_fu);
        rdy = issue_valid
            && !(issue_rs_en[0] && held(int'(issue_rs1)))
            && !(issue_rs_en[1] && held(int'(issue_rs2)))
            && !(issue_rd_en && held(int'(issue_rd)))
            && !(m_busy[fu] && !m_rel[fu])
            && !(issue_branch && m_sa && !branch_resolved)
            && !(branch_resolved && branch_miss);
        e.rdy = rdy; e.busy = m_busy_vec(); e.pend = m_pend(); e.sa = m_sa;
        q.push_back(e);
        if (exp_rdy >= 0) chk("directed_issue_ready", 32'(issue_ready), 32'(exp_rdy));
        sq   = branch_resolved && branch_miss && m_sa;
        hit  = branch_resolved && !branch_miss && m_sa;
        snow = m_sa && !branch_resolved;
        for (int f = 0; f < 4; f++) begin
            if (m_rel[f]) begin m_busy[f] = 0; m_spec[f] = 0; end
            if (sq && m_spec[f]) m_busy[f] = 0;
            if (sq || hit) m_spec[f] = 0;
        end
        if (rdy) begin
            m_busy[fu] = 1; m_rd[fu] = int'(issue_rd); m_wr[fu] = issue_rd_en; m_spec[fu] = snow;
        end
        m_sa = (m_sa && !branch_resolved) || (rdy && issue_branch);
        @(posedge CLK);
        #1;
        idle();
    endtask

    task automatic chk_state(input logic [3:0] b, input logic [31:0] p, input logic sa);
        chk("directed_fu_busy", 32'(fu_busy), 32'(b));
        chk("directed_reg_pending", reg_pending, p);
        chk("directed_spec_active", 32'(spec_active), 32'(sa));
    endtask

    // Asynchronous reset: outputs must clear before any clock edge
    task automatic do_reset();
        idle();
        issue_valid = 1;
        nRST = 0;
        #1;
        chk("reset_fu_busy", 32'(fu_busy), 32'd0);
        chk("reset_reg_pending", reg_pending, 32'd0);
        chk("reset_spec_active", 32'(spec_active), 32'd0);
        chk("reset_issue_ready", 32'(issue_ready), 32'd1);
        model_clear();
        @(posedge CLK);
        #1;
        nRST = 1;
        idle();
    endtask

    // Monitor: compare the DUT against each pushed expectation
    always @(negedge CLK) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("issue_ready", 32'(issue_ready), 32'(e.rdy));
            chk("fu_busy", 32'(fu_busy), 32'(e.busy));
            chk("reg_pending", reg_pending, e.pend);
            chk("spec_active", 32'(spec_active), 32'(e.sa));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        model_clear();
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // RAW with same-cycle wb bypass, rd=0, structural and WAW stalls
        set_issue(1, 5, 1, 0, 0, 2'b00, 0); go(1);
        chk_state(4'b0010, 32'h0000_0020, 0);
        set_issue(2, 9, 1, 5, 0, 2'b01, 0); go(0);
        set_issue(2, 9, 1, 5, 0, 2'b01, 0); wb_valid = 2'b01; wb_fu = 4'b0001; go(1);
        chk_state(4'b0100, 32'h0000_0200, 0);
        set_issue(0, 0, 1, 0, 0, 2'b00, 0); go(1);
        chk_state(4'b0101, 32'h0000_0200, 0);
        set_issue(0, 3, 1, 0, 0, 2'b00, 0); go(0);
        set_issue(1, 9, 1, 0, 0, 2'b00, 0); go(0);
        do_reset();

        // Branch miss squashes speculative FU2/FU3
        set_issue(0, 0, 0, 0, 0, 2'b00, 1); go(1);
        set_issue(2, 7, 1, 0, 0, 2'b00, 0); go(1);
        set_issue(3, 8, 1, 0, 0, 2'b00, 0); go(1);
        chk_state(4'b1101, 32'h0000_0180, 1);
        set_issue(1, 9, 1, 0, 0, 2'b00, 0); branch_resolved = 1; branch_miss = 1; go(0);
        chk_state(4'b0001, 32'h0000_0000, 0);
        do_reset();

        // Branch hit, spurious miss, branch window stall and hit bypass
        set_issue(0, 0, 0, 0, 0, 2'b00, 1); go(1);
        set_issue(2, 7, 1, 0, 0, 2'b00, 0); go(1);
        set_issue(3, 8, 1, 0, 0, 2'b00, 0); go(1);
        branch_resolved = 1; go(-1);
        chk_state(4'b1101, 32'h0000_0180, 0);
        branch_resolved = 1; branch_miss = 1; go(-1);
        chk_state(4'b1101, 32'h0000_0180, 0);
        set_issue(1, 0, 0, 0, 0, 2'b00, 1); go(1);
        chk_state(4'b1111, 32'h0000_0180, 1);
        set_issue(2, 0, 0, 0, 0, 2'b00, 1); wb_valid = 2'b01; wb_fu = 4'b0010; go(0);
        set_issue(2, 0, 0, 0, 0, 2'b00, 1); branch_resolved = 1; go(1);
        chk_state(4'b1111, 32'h0000_0100, 1);
        do_reset();

        // Randomized traffic with a mid-run asynchronous reset
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) do_reset();
            issue_valid  = ($urandom_range(0, 3) != 0);
            issue_fu     = 2'($urandom_range(0, 3));
            issue_rd     = 5'($urandom_range(0, 7));
            issue_rd_en  = 1'($urandom_range(0, 1));
            issue_rs1    = 5'($urandom_range(0, 7));
            issue_rs2    = 5'($urandom_range(0, 7));
            issue_rs_en  = 2'($urandom_range(0, 3));
            issue_branch = ($urandom_range(0, 6) == 0);
            wb_valid     = 2'($urandom_range(0, 3));
            wb_fu        = 4'($urandom_range(0, 15));
            branch_resolved = m_sa ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 31) == 0);
            branch_miss  = 1'($urandom_range(0, 1));
            go(-1);
        end

        @(negedge CLK);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
